// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one request per cycle to a 1-cycle-latency instruction
// memory, buffers returned words in a 3-entry FIFO and hands them to decode over valid/ready.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_ADDRESS = 32'd16
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] iaddr,
    output logic        ireq,
    input  logic [31:0] instruction,
    input  logic        isValid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_pc_q [3];
    logic [31:0] fifo_pc_d [3];
    logic [31:0] fifo_ins_q [3];
    logic [31:0] fifo_ins_d [3];
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic [2:0]  occupancy;
    logic        issue;
    logic        resp_ok;
    logic        push;
    logic        pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // In-flight requests reserve a FIFO slot, so a push can never find the buffer full.
    assign occupancy = {1'b0, count_q} + {2'b0, inflight_q};
    assign issue     = resetn && !fault_q && !redirect_valid && (occupancy < 3'd3);
    assign resp_ok   = inflight_q && !fault_q && !redirect_valid;
    assign push      = resp_ok && isValid;
    assign pop       = (count_q != 2'd0) && out_ready && !redirect_valid;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_pc_d  = fifo_pc_q;
        fifo_ins_d = fifo_ins_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            count_d  = 2'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            fault_d  = 1'b0;
        end else begin
            if (issue) begin
                resp_pc_d = pc_q;
                pc_d      = pc_q + 32'd4;
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]  = resp_pc_q;
                fifo_ins_d[wr_ptr_q] = instruction;
                wr_ptr_d             = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
            if (resp_ok && !isValid) begin
                fault_d    = 1'b1;
                fault_pc_d = resp_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= RESET_ADDRESS;
            inflight_q <= 1'b0;
            resp_pc_q  <= 32'd0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_pc_q[i]  <= 32'd0;
                fifo_ins_q[i] <= 32'd0;
            end
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_ins_q <= fifo_ins_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign iaddr           = pc_q;
    assign ireq            = issue;
    assign out_valid       = (count_q != 2'd0);
    assign out_pc          = fifo_pc_q[rd_ptr_q];
    assign out_instruction = fifo_ins_q[rd_ptr_q];
    assign fetch_fault     = fault_q;
    assign fault_pc        = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model, queue-based reference of the fetch rules,
// per-cycle comparison, directed scenarios with literal expectations, then random traffic.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] iaddr;
    logic        ireq;
    logic [31:0] instruction;
    logic        isValid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_ADDRESS(32'd16)) dut (
        .clk(clk), .resetn(resetn), .iaddr(iaddr), .ireq(ireq),
        .instruction(instruction), .isValid(isValid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    // Instruction memory: valid for aligned addresses in [16, mem_hi), data one cycle later.
    logic [31:0] mem_hi   = 32'd64;
    logic [31:0] mem_addr = 32'd0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic logic mem_ok(input logic [31:0] a, input logic [31:0] hi);
        return (a >= 32'd16) && (a < hi) && (a[1:0] == 2'b00);
    endfunction

    assign instruction = mem_data(mem_addr);
    assign isValid     = mem_ok(mem_addr, mem_hi);

    always @(posedge clk) begin
        if (ireq) mem_addr <= iaddr;
    end

    // Reference model: the buffer is a queue of {pc, instruction}.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_inflight;
    logic [31:0] m_resp_pc;
    bit          m_fault;
    logic [31:0] m_fault_pc;

    task automatic model_reset();
        m_q.delete();
        m_pc       = 32'd16;
        m_inflight = 1'b0;
        m_resp_pc  = 32'd0;
        m_fault    = 1'b0;
        m_fault_pc = 32'd0;
    endtask

    function automatic bit model_ireq();
        return !m_fault && !redirect_valid && ((m_q.size() + int'(m_inflight)) < 3);
    endfunction

    task automatic model_step();
        bit iss;
        iss = model_ireq();
        if (redirect_valid) begin
            m_q.delete();
            m_fault    = 1'b0;
            m_pc       = redirect_pc;
            m_inflight = 1'b0;
        end else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (m_inflight && !m_fault) begin
                if (mem_ok(m_resp_pc, mem_hi)) begin
                    m_q.push_back({m_resp_pc, mem_data(m_resp_pc)});
                end else begin
                    m_fault    = 1'b1;
                    m_fault_pc = m_resp_pc;
                end
            end
            if (iss) begin
                m_resp_pc  = m_pc;
                m_inflight = 1'b1;
                m_pc       = m_pc + 32'd4;
            end else begin
                m_inflight = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk1("ireq", ireq, model_ireq());
        chk("iaddr", iaddr, m_pc);
        chk1("out_valid", out_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("out_pc", out_pc, m_q[0][63:32]);
            chk("out_instruction", out_instruction, m_q[0][31:0]);
        end
        chk1("fetch_fault", fetch_fault, m_fault);
        chk("fault_pc", fault_pc, m_fault_pc);
    endtask

    // One cycle: drive at negedge, compare just after, advance the model.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        compare();
        model_step();
    endtask

    task automatic reset_assert();
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        model_reset();
    endtask

    task automatic reset_release();
        @(posedge clk);
        #2 resetn = 1'b1;
    endtask

    task automatic check_reset_values();
        chk("rst_iaddr", iaddr, 32'd16);
        chk1("rst_ireq", ireq, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instruction", out_instruction, 32'd0);
        chk1("rst_fetch_fault", fetch_fault, 1'b0);
        chk("rst_fault_pc", fault_pc, 32'd0);
    endtask

    initial begin
        reset_assert();
        repeat (3) @(posedge clk);
        #1 check_reset_values();
        reset_release();

        // Sequential fetch until the end of memory at 64.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            if (i == 0) begin
                chk1("first_ireq", ireq, 1'b1);
                chk("first_iaddr", iaddr, 32'd16);
            end
            if (i == 1) chk1("latency_not_yet", out_valid, 1'b0);
            if (i >= 2 && i <= 4) chk("seq_out_pc", out_pc, 32'd16 + 32'(4 * (i - 2)));
            if (i == 13) chk("last_good_pc", out_pc, 32'd60);
            if (i == 14) begin
                chk1("fault_no_entry", out_valid, 1'b0);
                chk1("fault_ireq_low", ireq, 1'b0);
                chk1("fault_set", fetch_fault, 1'b1);
                chk("fault_pc_64", fault_pc, 32'd64);
            end
            if (i == 19) chk1("fault_ireq_stays_low", ireq, 1'b0);
        end

        // Redirect to 16 clears the fault and resumes delivery.
        cycle(1'b1, 32'd16, 1'b1);
        chk1("redir_ireq_low", ireq, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            cycle(1'b0, 32'd0, 1'b1);
            if (j == 1) begin
                chk1("redir_fault_clear", fetch_fault, 1'b0);
                chk("redir_fault_pc_holds", fault_pc, 32'd64);
                chk("redir_iaddr", iaddr, 32'd16);
            end
            if (j == 3) chk("redir_out_pc", out_pc, 32'd16);
        end

        // Decode stalled for 10 cycles from reset.
        reset_assert();
        reset_release();
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 32'd0, i >= 10);
            if (i == 9) begin
                chk1("stall_full_valid", out_valid, 1'b1);
                chk1("stall_ireq_low", ireq, 1'b0);
            end
            if (i >= 10) chk("stall_release_pc", out_pc, 32'd16 + 32'(4 * (i - 10)));
        end

        // Redirect to 40 with entries buffered.
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'd40, 1'b1);
        for (int j = 1; j <= 5; j++) begin
            cycle(1'b0, 32'd0, 1'b1);
            if (j == 1) chk("r40_iaddr", iaddr, 32'd40);
            if (j == 2) chk1("r40_flushed", out_valid, 1'b0);
            if (j == 3) chk("r40_out_pc", out_pc, 32'd40);
        end

        // Misaligned redirect faults, redirect to 16 recovers.
        cycle(1'b1, 32'd42, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            cycle(1'b0, 32'd0, 1'b1);
            if (j == 1) chk("r42_iaddr", iaddr, 32'd42);
            if (j == 3) begin
                chk1("r42_fault", fetch_fault, 1'b1);
                chk("r42_fault_pc", fault_pc, 32'd42);
            end
        end
        cycle(1'b1, 32'd16, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            cycle(1'b0, 32'd0, 1'b1);
            if (j == 1) chk1("r16_fault_clear", fetch_fault, 1'b0);
            if (j == 3) chk("r16_out_pc", out_pc, 32'd16);
        end

        // Asynchronous reset with the buffer full.
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b0);
        chk1("pre_reset_full", out_valid, 1'b1);
        #2;
        reset_assert();
        #1 check_reset_values();
        reset_release();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            if (i == 0) chk("restart_iaddr", iaddr, 32'd16);
            if (i == 2) chk("restart_out_pc", out_pc, 32'd16);
        end

        // Random traffic over a larger memory.
        mem_hi = 32'd512;
        reset_assert();
        reset_release();
        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic [31:0] rpc;
            int          r;
            rv  = ($urandom_range(0, 29) == 0);
            r   = $urandom_range(0, 9);
            rpc = 32'd16 + 32'(4 * $urandom_range(0, 120));
            if (r == 0) rpc = rpc + 32'd2;
            if (r == 1) rpc = 32'd600;
            cycle(rv, rpc, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
